ram_arbiter2: RTL



---
 rtl/ram_arbiter2.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter2.sv
// ram_arbiter2: round-robin two-port sequencer for a single-port RAM.
// Ports: clk/reset; per requester reqN,wrenN,addrN,dinN -> gntN,rvalidN,
// rdataN; RAM side ram_addr/ram_din/ram_wren -> ram_dout; busy while clearing.
// Optional macro RAM_ARB_CLEAR_EN: zero-fill every RAM word after reset.
module ram_arbiter2 #(
  parameter int AW = 5,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          wren0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wren1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  logic          clearing;
  logic [AW-1:0] clr_addr;

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic {CLEAR, SERVE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Counter wraps to 0 on the last word, leaving it ready for next reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_d = SERVE;
    end
  end

  assign clearing = (state_q == CLEAR);
  assign clr_addr = clr_cnt_q;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          tv_q, tv_d;
  logic          tp_q, tp_d;
  logic          serve;
  logic          pick0, pick1;

  // last_q = 1 means port 1 was granted last, so port 0 wins a tie.
  assign serve = ~clearing & ~reset;
  assign pick0 = serve & req0 & (~req1 | last_q);
  assign pick1 = serve & req1 & (~req0 | ~last_q);

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    ram_wren = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    last_d   = last_q;
    addr_d   = addr_q;
    din_d    = din_q;
    tv_d     = 1'b0;
    tp_d     = tp_q;
    if (clearing) begin
      ram_wren = 1'b1;
      ram_addr = clr_addr;
      ram_din  = '0;
    end else begin
      unique case (1'b1)
        pick0: begin
          gnt0     = 1'b1;
          ram_wren = wren0;
          ram_addr = addr0;
          ram_din  = din0;
          last_d   = 1'b0;
          addr_d   = addr0;
          din_d    = din0;
          tv_d     = 1'b1;
          tp_d     = 1'b0;
        end
        pick1: begin
          gnt1     = 1'b1;
          ram_wren = wren1;
          ram_addr = addr1;
          ram_din  = din1;
          last_d   = 1'b1;
          addr_d   = addr1;
          din_d    = din1;
          tv_d     = 1'b1;
          tp_d     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
      tv_q   <= 1'b0;
      tp_q   <= 1'b0;
    end else begin
      last_q <= last_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      tv_q   <= tv_d;
      tp_q   <= tp_d;
    end
  end

  // RAM output is registered, so the tag lines up with ram_dout.
  assign rvalid0 = tv_q & ~tp_q;
  assign rvalid1 = tv_q & tp_q;
  assign rdata0  = rvalid0 ? ram_dout : '0;
  assign rdata1  = rvalid1 ? ram_dout : '0;
  assign busy    = clearing;

endmodule
